// File: rtl/sdram_port_arbiter.sv
// Arbiter sharing one SDRAM controller port between video row preloads and a
// general read/write client. Video has strict priority; client bursts are capped.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH       = 23,
  parameter int BURST_WIDTH      = 9,
  parameter int CLIENT_MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vid_rd_request,
  input  logic [ADDR_WIDTH-1:0]  vid_rd_address,
  input  logic [BURST_WIDTH-1:0] vid_rd_burst_length,
  output logic                   vid_rd_available,
  output logic [31:0]            vid_rd_data,
  input  logic                   cl_request,
  input  logic                   cl_write,
  input  logic [ADDR_WIDTH-1:0]  cl_address,
  input  logic [BURST_WIDTH-1:0] cl_burst_length,
  output logic                   cl_ack,
  input  logic [31:0]            cl_wr_data,
  output logic                   cl_wr_next,
  output logic                   cl_rd_available,
  output logic [31:0]            cl_rd_data,
  output logic                   cl_done,
  output logic                   ctl_request,
  output logic                   ctl_write,
  output logic [ADDR_WIDTH-1:0]  ctl_address,
  output logic [BURST_WIDTH-1:0] ctl_burst_length,
  output logic [31:0]            ctl_wr_data,
  input  logic                   ctl_wr_next,
  input  logic                   ctl_rd_available,
  input  logic [31:0]            ctl_rd_data,
  input  logic                   ctl_busy,
  output logic                   video_overrun
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_TRANSFER  = 2'd3;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_VIDEO  = 2'd1;
  localparam logic [1:0] OWN_CLIENT = 2'd2;

  localparam logic [BURST_WIDTH-1:0] MAX_BURST = BURST_WIDTH'(CLIENT_MAX_BURST);
  localparam logic [BURST_WIDTH-1:0] ONE_BURST = BURST_WIDTH'(1);

  function automatic logic [BURST_WIDTH-1:0] clamp_burst(input logic [BURST_WIDTH-1:0] len);
    logic [BURST_WIDTH-1:0] res;
    if (len == {BURST_WIDTH{1'b0}}) begin
      res = ONE_BURST;
    end else if (len > MAX_BURST) begin
      res = MAX_BURST;
    end else begin
      res = len;
    end
    return res;
  endfunction

  logic [1:0]             state_r;
  logic [1:0]             owner_r;
  logic                   vid_pending_r;
  logic                   vid_req_d_r;
  logic [ADDR_WIDTH-1:0]  vid_addr_r;
  logic [BURST_WIDTH-1:0] vid_len_r;
  logic                   video_overrun_r;
  logic                   ctl_request_r;
  logic                   ctl_write_r;
  logic [ADDR_WIDTH-1:0]  ctl_address_r;
  logic [BURST_WIDTH-1:0] ctl_burst_length_r;
  logic                   cl_ack_r;
  logic                   cl_done_r;

  logic vid_capture_s;
  logic vid_rise_s;
  logic vid_clear_s;
  logic data_phase_s;

  // A video request being captured this cycle blocks the client so video wins ties.
  assign vid_capture_s = vid_rd_request & ~vid_pending_r;
  assign vid_rise_s    = vid_rd_request & ~vid_req_d_r;
  assign vid_clear_s   = (state_r == ST_ISSUE) && (owner_r == OWN_VIDEO);
  assign data_phase_s  = (state_r == ST_WAIT_BUSY) || (state_r == ST_TRANSFER);

  // Video request capture, pending flag and sticky overrun detection
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pending_r   <= 1'b0;
      vid_req_d_r     <= 1'b0;
      vid_addr_r      <= {ADDR_WIDTH{1'b0}};
      vid_len_r       <= {BURST_WIDTH{1'b0}};
      video_overrun_r <= 1'b0;
    end else begin
      vid_req_d_r <= vid_rd_request;
      if (vid_capture_s) begin
        vid_pending_r <= 1'b1;
        vid_addr_r    <= vid_rd_address;
        vid_len_r     <= vid_rd_burst_length;
      end else begin
        if (vid_rise_s) begin
          video_overrun_r <= 1'b1;
        end
        if (vid_clear_s) begin
          vid_pending_r <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM and registered command/handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      owner_r            <= OWN_NONE;
      ctl_request_r      <= 1'b0;
      ctl_write_r        <= 1'b0;
      ctl_address_r      <= {ADDR_WIDTH{1'b0}};
      ctl_burst_length_r <= {BURST_WIDTH{1'b0}};
      cl_ack_r           <= 1'b0;
      cl_done_r          <= 1'b0;
    end else begin
      ctl_request_r <= 1'b0;
      cl_ack_r      <= 1'b0;
      cl_done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (vid_pending_r) begin
            owner_r            <= OWN_VIDEO;
            ctl_write_r        <= 1'b0;
            ctl_address_r      <= vid_addr_r;
            ctl_burst_length_r <= vid_len_r;
            ctl_request_r      <= 1'b1;
            state_r            <= ST_ISSUE;
          end else if (cl_request && !vid_capture_s) begin
            owner_r            <= OWN_CLIENT;
            ctl_write_r        <= cl_write;
            ctl_address_r      <= cl_address;
            ctl_burst_length_r <= clamp_burst(cl_burst_length);
            ctl_request_r      <= 1'b1;
            cl_ack_r           <= 1'b1;
            state_r            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (ctl_busy) begin
            state_r <= ST_TRANSFER;
          end
        end
        ST_TRANSFER: begin
          if (!ctl_busy) begin
            cl_done_r <= (owner_r == OWN_CLIENT);
            owner_r   <= OWN_NONE;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          owner_r <= OWN_NONE;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctl_request      = ctl_request_r;
  assign ctl_write        = ctl_write_r;
  assign ctl_address      = ctl_address_r;
  assign ctl_burst_length = ctl_burst_length_r;
  assign cl_ack           = cl_ack_r;
  assign cl_done          = cl_done_r;
  assign video_overrun    = video_overrun_r;

  // Data beats steer to the current owner only; ownerless beats are dropped.
  assign vid_rd_available = ctl_rd_available & data_phase_s & (owner_r == OWN_VIDEO);
  assign cl_rd_available  = ctl_rd_available & data_phase_s & (owner_r == OWN_CLIENT);
  assign cl_wr_next       = ctl_wr_next & (owner_r == OWN_CLIENT);
  assign vid_rd_data      = ctl_rd_data;
  assign cl_rd_data       = ctl_rd_data;
  assign ctl_wr_data      = cl_wr_data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a small SDRAM controller model
// answers commands, a negedge monitor checks commands and counts routed beats.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_rd_request;
  logic [22:0] vid_rd_address;
  logic [8:0]  vid_rd_burst_length;
  logic        vid_rd_available;
  logic [31:0] vid_rd_data;
  logic        cl_request;
  logic        cl_write;
  logic [22:0] cl_address;
  logic [8:0]  cl_burst_length;
  logic        cl_ack;
  logic [31:0] cl_wr_data;
  logic        cl_wr_next;
  logic        cl_rd_available;
  logic [31:0] cl_rd_data;
  logic        cl_done;
  logic        ctl_request;
  logic        ctl_write;
  logic [22:0] ctl_address;
  logic [8:0]  ctl_burst_length;
  logic [31:0] ctl_wr_data;
  logic        ctl_wr_next;
  logic        ctl_rd_available;
  logic [31:0] ctl_rd_data;
  logic        ctl_busy;
  logic        video_overrun;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_rd_request(vid_rd_request), .vid_rd_address(vid_rd_address),
    .vid_rd_burst_length(vid_rd_burst_length), .vid_rd_available(vid_rd_available),
    .vid_rd_data(vid_rd_data),
    .cl_request(cl_request), .cl_write(cl_write), .cl_address(cl_address),
    .cl_burst_length(cl_burst_length), .cl_ack(cl_ack), .cl_wr_data(cl_wr_data),
    .cl_wr_next(cl_wr_next), .cl_rd_available(cl_rd_available), .cl_rd_data(cl_rd_data),
    .cl_done(cl_done),
    .ctl_request(ctl_request), .ctl_write(ctl_write), .ctl_address(ctl_address),
    .ctl_burst_length(ctl_burst_length), .ctl_wr_data(ctl_wr_data),
    .ctl_wr_next(ctl_wr_next), .ctl_rd_available(ctl_rd_available),
    .ctl_rd_data(ctl_rd_data), .ctl_busy(ctl_busy), .video_overrun(video_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [22:0] a;
    logic [8:0]  l;
    logic        client;
    int          cyc;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vid_beats = 0;
  int cl_rd_beats = 0;
  int wr_beats = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [22:0] a, input logic [8:0] l,
                          input logic client, input int c);
    cmd_t e;
    e.w = w; e.a = a; e.l = l; e.client = client; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vid_pulse(input logic [22:0] a, input logic [8:0] l);
    vid_rd_address = a;
    vid_rd_burst_length = l;
    vid_rd_request = 1'b1;
    @(posedge clk);
    #1 vid_rd_request = 1'b0;
  endtask

  task automatic cl_start(input logic w, input logic [22:0] a, input logic [8:0] l);
    cl_write = w;
    cl_address = a;
    cl_burst_length = l;
    cl_request = 1'b1;
  endtask

  task automatic wait_ack(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cl_ack) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 cl_request = 1'b0;
    check(name, 64'(got), 64'(1'b1));
  endtask

  // Controller model: busy for the whole burst, one beat per cycle, aborts on reset
  initial begin : ctl_model
    logic m_w;
    int   m_n;
    logic aborted;
    ctl_busy = 1'b0;
    ctl_rd_available = 1'b0;
    ctl_wr_next = 1'b0;
    ctl_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (ctl_request && !reset) begin
        m_w = ctl_write;
        m_n = int'(ctl_burst_length);
        aborted = 1'b0;
        @(posedge clk);
        #1 ctl_busy = 1'b1;
        for (int i = 0; i < m_n; i++) begin
          @(posedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          #1;
          if (m_w) begin
            ctl_wr_next = 1'b1;
          end else begin
            ctl_rd_available = 1'b1;
            ctl_rd_data = 32'hD000_0000 + 32'(i);
          end
        end
        if (!aborted) @(posedge clk);
        #1;
        ctl_busy = 1'b0;
        ctl_wr_next = 1'b0;
        ctl_rd_available = 1'b0;
      end
    end
  end

  // Monitor: pops the expected command on every strobe and tallies routed beats
  always @(negedge clk) begin
    if (!reset) begin
      if (ctl_request) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {41'd0, ctl_address}, 64'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_fields", {29'd0, ctl_write, ctl_address, ctl_burst_length, cl_ack, ctl_busy},
                {29'd0, mon_e.w, mon_e.a, mon_e.l, mon_e.client, 1'b0});
          if (mon_e.cyc >= 0) check("cmd_latency", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (cl_ack) begin
        check("ack_without_cmd", 64'(cl_ack), 64'(1'b0));
      end
      if (vid_rd_available && cl_rd_available) begin
        check("dual_route", 64'(1'b1), 64'(1'b0));
      end
      if (vid_rd_available) vid_beats++;
      if (cl_rd_available) cl_rd_beats++;
      if (cl_wr_next) wr_beats++;
      if (cl_done) done_cnt++;
    end
  end

  initial begin : stim
    reset = 1'b1;
    vid_rd_request = 1'b0;
    vid_rd_address = 23'h0;
    vid_rd_burst_length = 9'd0;
    cl_request = 1'b0;
    cl_write = 1'b0;
    cl_address = 23'h0;
    cl_burst_length = 9'd0;
    cl_wr_data = 32'hCAFE_0001;
    run(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          64'({vid_rd_available, cl_ack, cl_wr_next, cl_rd_available, cl_done, ctl_request,
               ctl_write, ctl_address, ctl_burst_length, video_overrun}), 64'd0);
    check("wr_data_pass", 64'(ctl_wr_data), 64'h0000_0000_CAFE_0001);
    run(1);

    // Video only: 2-cycle latency, 80 beats routed to video
    push_cmd(1'b0, 23'h001000, 9'd80, 1'b0, cyc + 2);
    vid_pulse(23'h001000, 9'd80);
    run(100);
    check("t1_vid_beats", 64'(vid_beats), 64'd80);
    check("t1_cl_beats", 64'(cl_rd_beats), 64'd0);

    // Simultaneous: video first, then client write of 4
    push_cmd(1'b0, 23'h002000, 9'd8, 1'b0, -1);
    push_cmd(1'b1, 23'h000020, 9'd4, 1'b1, -1);
    cl_start(1'b1, 23'h000020, 9'd4);
    vid_pulse(23'h002000, 9'd8);
    wait_ack("t2_ack");
    run(30);
    check("t2_vid_beats", 64'(vid_beats), 64'd88);
    check("t2_wr_beats", 64'(wr_beats), 64'd4);
    check("t2_done", 64'(done_cnt), 64'd1);

    // Clamp: 100 -> 16, 0 -> 1
    push_cmd(1'b0, 23'h000300, 9'd16, 1'b1, -1);
    cl_start(1'b0, 23'h000300, 9'd100);
    wait_ack("t3_ack_a");
    run(40);
    push_cmd(1'b0, 23'h000400, 9'd1, 1'b1, -1);
    cl_start(1'b0, 23'h000400, 9'd0);
    wait_ack("t3_ack_b");
    run(20);
    check("t3_cl_beats", 64'(cl_rd_beats), 64'd17);
    check("t3_done", 64'(done_cnt), 64'd3);

    // Video arriving during a client burst keeps its latched address
    push_cmd(1'b0, 23'h000500, 9'd10, 1'b1, -1);
    push_cmd(1'b0, 23'h006000, 9'd5, 1'b0, -1);
    cl_start(1'b0, 23'h000500, 9'd10);
    wait_ack("t4_ack");
    run(4);
    vid_pulse(23'h006000, 9'd5);
    vid_rd_address = 23'h007777;
    vid_rd_burst_length = 9'd9;
    run(60);
    check("t4_cl_beats", 64'(cl_rd_beats), 64'd27);
    check("t4_vid_beats", 64'(vid_beats), 64'd93);
    check("t4_done", 64'(done_cnt), 64'd4);
    check("t4_no_overrun", 64'(video_overrun), 64'd0);

    // Overrun: second pulse while first still pending is dropped
    push_cmd(1'b1, 23'h000700, 9'd16, 1'b1, -1);
    push_cmd(1'b0, 23'h008000, 9'd3, 1'b0, -1);
    cl_start(1'b1, 23'h000700, 9'd16);
    wait_ack("t5_ack");
    run(2);
    vid_pulse(23'h008000, 9'd3);
    run(1);
    vid_pulse(23'h009000, 9'd7);
    run(80);
    check("t5_overrun", 64'(video_overrun), 64'd1);
    check("t5_vid_beats", 64'(vid_beats), 64'd96);
    check("t5_wr_beats", 64'(wr_beats), 64'd20);
    check("t5_done", 64'(done_cnt), 64'd5);

    // Reset during a client transfer
    push_cmd(1'b1, 23'h000A00, 9'd16, 1'b1, -1);
    cl_start(1'b1, 23'h000A00, 9'd16);
    wait_ack("t6_ack");
    run(5);
    check("t6_overrun_sticky", 64'(video_overrun), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_reset_outputs",
          64'({vid_rd_available, cl_ack, cl_wr_next, cl_rd_available, cl_done, ctl_request,
               ctl_write, ctl_address, ctl_burst_length, video_overrun}), 64'd0);
    run(5);
    check("t6_no_done", 64'(done_cnt), 64'd5);
    push_cmd(1'b0, 23'h000B00, 9'd2, 1'b1, -1);
    cl_start(1'b0, 23'h000B00, 9'd2);
    wait_ack("t6_ack_after");
    run(20);
    check("t6_done", 64'(done_cnt), 64'd6);
    check("t6_cl_beats", 64'(cl_rd_beats), 64'd29);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port between the video controller's row-preload reads and one general client (terminal writer / CPU) doing reads or writes.
- Video has strict priority so a character row is always fetched within one scanline; client bursts are length-capped to bound video latency.
- Sits between the video controller / client and the SDRAM controller; routes data beats only to the current owner.

Parameters:
- ADDR_WIDTH, 23, SDRAM word address width
- BURST_WIDTH, 9, burst length field width
- CLIENT_MAX_BURST, 16, maximum client burst; larger requests are clamped

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- vid_rd_request  in  1  one-cycle (or longer) pulse requesting a row preload
- vid_rd_address  in  23  video burst start address, sampled with request
- vid_rd_burst_length  in  9  video burst length, sampled with request
- vid_rd_available  out  1  video read beat valid
- vid_rd_data  out  32  read data to video
- cl_request  in  1  client request level; held until cl_ack
- cl_write  in  1  1 = write burst, 0 = read burst
- cl_address  in  23  client start address
- cl_burst_length  in  9  client burst length (0 treated as 1)
- cl_ack  out  1  one-cycle pulse: client request accepted and issued
- cl_wr_data  in  32  client write data, current beat
- cl_wr_next  out  1  controller consumed cl_wr_data this cycle
- cl_rd_available  out  1  client read beat valid
- cl_rd_data  out  32  read data to client
- cl_done  out  1  one-cycle pulse: client transfer complete
- ctl_request  out  1  one-cycle command strobe to SDRAM controller
- ctl_write  out  1  command direction
- ctl_address  out  23  command address
- ctl_burst_length  out  9  command burst length
- ctl_wr_data  out  32  write data (= cl_wr_data, combinational)
- ctl_wr_next  in  1  controller consumes one write beat
- ctl_rd_available  in  1  read beat valid from controller
- ctl_rd_data  in  32  read data from controller
- ctl_busy  in  1  high from cycle after ctl_request until transfer finished
- video_overrun  out  1  sticky: video request arrived while previous still pending

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags cleared, video_overrun cleared. Reset mid-transfer abandons ownership immediately; no cl_done issued.
- Video capture: rising-or-high vid_rd_request with no video pending sets vid_pending and latches address/length in same cycle. If vid_pending already set and request seen again (new pulse after a low cycle), video_overrun <= 1, latched values unchanged.
- States: IDLE, ISSUE, WAIT_BUSY, TRANSFER.
- IDLE: vid_pending -> owner=VIDEO, go ISSUE; else cl_request -> owner=CLIENT, latch client fields, burst = min(max(len,1), CLIENT_MAX_BURST), go ISSUE. Video wins on simultaneous requests.
- ISSUE (1 cycle): ctl_request=1 with registered address/length/write (video always write=0); cl_ack=1 if owner CLIENT; vid_pending cleared if owner VIDEO. Go WAIT_BUSY.
- WAIT_BUSY: ctl_busy=1 -> TRANSFER. Stays here otherwise (no timeout).
- TRANSFER: ctl_busy=0 -> IDLE; cl_done=1 that cycle if owner CLIENT. New arbitration earliest next cycle.
- Routing (combinational, zero latency): vid_rd_available = ctl_rd_available & owner VIDEO & state in {WAIT_BUSY,TRANSFER}; same for client; ctl_rd_available with no owner dropped. cl_wr_next = ctl_wr_next & owner CLIENT. vid_rd_data = cl_rd_data = ctl_rd_data.
- Request-to-ctl_request latency: 2 cycles from IDLE with pending request.
- No preemption: in-flight client burst completes before video issues; worst-case video wait = one capped client burst.
- Client lowering cl_request before cl_ack: request withdrawn if still in IDLE; ignored once ISSUE reached.

Test Plan:
- Video only: pulse vid_rd_request, addr 0x001000, len 80 -> ctl_request 2 cycles later with same addr/len, ctl_write=0; 80 beats appear on vid_rd_available only.
- Simultaneous: vid and cl (write, addr 0x20, len 4) same cycle -> video issued first; client cl_ack after video ctl_busy falls; 4 cl_wr_next pulses, then cl_done.
- Clamp: cl read len 100 -> ctl_burst_length=16; len 0 -> 1.
- Video during client burst: vid pulse mid client transfer -> no ctl_request until ctl_busy low, then video issued with originally latched address even if vid_rd_address changed.
- Overrun: two vid pulses before first issued -> video_overrun=1, sticky until reset; second address not used.
- Reset in TRANSFER -> all outputs 0 next cycle, no cl_done, next request arbitrates normally.
